// File: rtl/i2c_master_seq_if.sv
// Request/response handshake and I2C pin bundle for the single-master sequencer.
// The master modport is the sequencer's view; the slave modport is the host/bench view.
interface i2c_master_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic       req_rw;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       busy;
  logic       i2c_scl;
  logic       i2c_sda_oe;
  logic       i2c_sda_i;

  modport master (
    input  req_valid, req_addr, req_rw, req_wdata, i2c_sda_i,
    output req_ready, rsp_valid, rsp_rdata, rsp_nack, busy, i2c_scl, i2c_sda_oe
  );

  modport slave (
    output req_valid, req_addr, req_rw, req_wdata, i2c_sda_i,
    input  req_ready, rsp_valid, rsp_rdata, rsp_nack, busy, i2c_scl, i2c_sda_oe
  );
endinterface

// File: rtl/i2c_master_seq.sv
// Single-master I2C sequencer: one request becomes START, addr+R/W, one data byte, STOP.
// Each bus phase is split into four quarters of CLK_DIV clocks; SDA only moves at Q0.
module i2c_master_seq #(
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             s_reset,
  i2c_master_seq_if.master bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_AACK  = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_DACK  = 3'd5;
  localparam logic [2:0] S_STOP  = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             rw_q, rw_d;
  logic             nack_q, nack_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             rsp_nack_q, rsp_nack_d;
  logic             tick;
  logic             scl;
  logic             sda_oe;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    qtr_d       = qtr_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    wdata_d     = wdata_q;
    rw_d        = rw_q;
    nack_d      = nack_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_nack_d  = rsp_nack_q;
    tick        = (state_q != S_IDLE) && (div_q == DIV_MAX);

    if (state_q == S_IDLE) begin
      div_d = '0;
      if (bus.req_valid) begin
        state_d = S_START;
        qtr_d   = 2'd0;
        bit_d   = 4'd0;
        shreg_d = {bus.req_addr, bus.req_rw};
        wdata_d = bus.req_wdata;
        rw_d    = bus.req_rw;
        nack_d  = 1'b0;
      end
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
    end

    if (tick) begin
      qtr_d = qtr_q + 2'd1;
      case (state_q)
        S_START: begin
          if (qtr_q == 2'd3) begin
            state_d = S_ADDR;
            bit_d   = 4'd0;
          end
        end
        S_ADDR: begin
          if (qtr_q == 2'd3) begin
            shreg_d = {shreg_q[6:0], 1'b0};
            bit_d   = bit_q + 4'd1;
            if (bit_q == 4'd7) state_d = S_AACK;
          end
        end
        S_AACK: begin
          if (qtr_q == 2'd2 && bus.i2c_sda_i) nack_d = 1'b1;
          // An unacknowledged address skips the data byte entirely.
          if (qtr_q == 2'd3) begin
            if (nack_q) begin
              state_d = S_STOP;
            end else begin
              state_d = S_DATA;
              bit_d   = 4'd0;
              shreg_d = wdata_q;
            end
          end
        end
        S_DATA: begin
          if (rw_q && qtr_q == 2'd2) shreg_d = {shreg_q[6:0], bus.i2c_sda_i};
          if (!rw_q && qtr_q == 2'd3) shreg_d = {shreg_q[6:0], 1'b0};
          if (qtr_q == 2'd3) begin
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd7) state_d = S_DACK;
          end
        end
        S_DACK: begin
          // On reads this slot is the master's own NACK, so the line level is ignored.
          if (qtr_q == 2'd2 && !rw_q && bus.i2c_sda_i) nack_d = 1'b1;
          if (qtr_q == 2'd3) state_d = S_STOP;
        end
        S_STOP: begin
          if (qtr_q == 2'd3) begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b1;
            rsp_nack_d  = nack_q;
            if (rw_q && !nack_q) rsp_rdata_d = shreg_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    case (state_q)
      S_START: sda_oe = qtr_q[1];
      S_ADDR: begin
        scl    = qtr_q[1];
        sda_oe = ~shreg_q[7];
      end
      S_AACK, S_DACK: scl = qtr_q[1];
      S_DATA: begin
        scl    = qtr_q[1];
        sda_oe = ~rw_q & ~shreg_q[7];
      end
      S_STOP: begin
        scl    = qtr_q[1];
        sda_oe = (qtr_q != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge s_reset) begin
    if (s_reset) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      qtr_q       <= 2'd0;
      bit_q       <= 4'd0;
      shreg_q     <= 8'h00;
      wdata_q     <= 8'h00;
      rw_q        <= 1'b0;
      nack_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_nack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      qtr_q       <= qtr_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      wdata_q     <= wdata_d;
      rw_q        <= rw_d;
      nack_q      <= nack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_nack_q  <= rsp_nack_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_nack   = rsp_nack_q;
  assign bus.i2c_scl    = scl;
  assign bus.i2c_sda_oe = sda_oe;

endmodule

// File: doc/i2c_master_seq.md
# i2c_master_seq

Single-master I2C transaction sequencer that turns one-cycle requests into complete bus transfers on the `i2c_scl`/`i2c_sda` pins. Each request produces one transfer: START, 7-bit address plus R/W, one data byte, and STOP. It sits between the test/host request logic and the I2C pins that the master driver and monitor observe. It has no clock stretching and no multi-master arbitration.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per SCL quarter-phase. Must be ≥1. One SCL period is 4·`CLK_DIV` cycles.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `s_reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request strobe.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid & req_ready`.
- `req_addr`  in  7  slave address; captured at acceptance.
- `req_rw`  in  1  0 = write, 1 = read; captured at acceptance.
- `req_wdata`  in  8  write byte; captured at acceptance.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  8  read byte. Holds its value until the next read completes.
- `rsp_nack`  out  1  1 if any slave ACK slot sampled high. Valid with `rsp_valid`; holds until the next completion.
- `busy`  out  1  high from acceptance through the last STOP quarter.
- `i2c_scl`  out  1  SCL level (push-pull).
- `i2c_sda_oe`  out  1  1 = pull SDA low, 0 = release (bus high).
- `i2c_sda_i`  in  1  sampled SDA level.

## Operation
- Reset values: `req_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_rdata`=0x00, `rsp_nack`=0, `i2c_scl`=1, `i2c_sda_oe`=0, FSM in IDLE, counters 0.
- A quarter tick fires every `CLK_DIV` cycles while not in IDLE. A 2-bit quarter counter (Q0..Q3) and a 4-bit bit counter advance on ticks.
- FSM states: IDLE → START → ADDR → AACK → DATA → DACK → STOP → IDLE.
- START (4 quarters): SCL=1 in Q0–Q3. SDA released in Q0–Q1, pulled low in Q2–Q3.
- Bit slot (ADDR/AACK/DATA/DACK, 4 quarters each): SCL=0 in Q0–Q1, SCL=1 in Q2–Q3.
  - SDA changes only at the start of Q0.
  - `i2c_sda_i` is sampled on the tick ending Q2.
- ADDR: 8 slots, MSB first, shifting out {`req_addr`, `req_rw`}. SDA pulled low for 0, released for 1.
- AACK: SDA released. A sampled 1 sets the NACK flag and jumps directly to STOP, skipping DATA/DACK.
- DATA, write: 8 slots MSB first from `req_wdata`.
- DATA, read: SDA released. Sampled bits shift into `rsp_rdata` MSB first.
- DACK, write: SDA released. A sampled 1 sets the NACK flag; the transfer still proceeds to STOP.
- DACK, read: master sends NACK (SDA released, single-byte read). This slot never sets the NACK flag.
- STOP (4 quarters): SDA pulled low in Q0–Q2, released in Q3. SCL=0 in Q0–Q1, SCL=1 in Q2–Q3.
- After the STOP Q3 tick, return to IDLE.
  - `rsp_valid`=1 for exactly that first IDLE cycle.
  - `busy`=0 and `req_ready`=1 in that cycle.
  - A request can be accepted in the same cycle as `rsp_valid`.
- `req_valid` is ignored while busy. Request fields are registered, so later changes to them have no effect on a transfer in flight.
- `rsp_rdata` is unchanged by write transfers and by address-NACKed transfers.

## Timing
- Acceptance on edge T. The first START quarter covers cycles T+1..T+`CLK_DIV`.
- Full transfer = START(4) + 18 slots(72) + STOP(4) = 80 quarters. `rsp_valid` is high in cycle T+80·`CLK_DIV`+1.
- Address-NACK transfer = 4 + 36 + 4 = 44 quarters. `rsp_valid` is high in cycle T+44·`CLK_DIV`+1.
- Back-to-back: with `req_valid` held high, the next START begins the cycle after the `rsp_valid` cycle.
- SDA never changes while SCL=1, except for the START and STOP edges.
- Reset mid-transfer: outputs go to reset values immediately (SCL=1, SDA released). No STOP is issued and no `rsp_valid` is produced.
- `CLK_DIV`=1 is legal: one quarter per cycle.

## Test plan
- Write, `CLK_DIV`=4, addr 0x50, wdata 0xA5, slave ACKs both slots.
  - SDA bytes decoded on SCL rise: 0xA0 then 0xA5.
  - `rsp_valid` exactly 321 cycles after acceptance, `rsp_nack`=0.
- Read, addr 0x3C, slave drives 0x96 and ACKs the address.
  - Address byte 0x79, `rsp_rdata`=0x96, `rsp_nack`=0.
  - SDA released in the DACK slot; `rsp_valid` at +321.
- Address NACK (no slave).
  - STOP follows the 9th slot; `rsp_valid` at cycle +177 (`CLK_DIV`=4), `rsp_nack`=1.
  - `rsp_rdata` keeps its previous value.
- Write data NACK: slave ACKs the address and NACKs the data.
  - Full 80-quarter transfer, `rsp_nack`=1.
- Back-to-back writes with `req_valid` held high, `CLK_DIV`=1.
  - The second START begins the cycle after the first `rsp_valid`.
  - Exactly two `rsp_valid` pulses, 81 cycles apart.
- Assert `s_reset` during the DATA state.
  - `i2c_scl`=1, `i2c_sda_oe`=0, `busy`=0, `req_ready`=1 in the same cycle, no `rsp_valid`.
  - A new request after reset completes normally.
